multi_led_toggle: RTL

- Parametrised, multi-channel successor to the single-button LED toggle.
- Each of NUM_CHANNELS inverting push buttons has its own 2-FF synchroniser, counter-based debouncer and falling-edge press detector.
- Each debounced press toggles that channel's LED enable.
- A per-channel mode bit selects steady-on or blinking output; all channels share one blink timebase.
- Sits between the board push buttons and LEDs in top-level designs.

---
 rtl/multi_led_toggle_pkg.sv | 14 +
 rtl/multi_led_toggle_if.sv | 32 +++
 rtl/multi_led_toggle_button_debouncer.sv | 54 +++++
 rtl/multi_led_toggle.sv | 61 ++++++
 4 files changed

// File: rtl/multi_led_toggle_pkg.sv
// Package shared by the multi-channel LED toggle slice.
// Holds the board clock frequency and the default timing constants
// derived from it.
package led_toggle_pkg;

    localparam int CLOCK_FREQ_HZ = 50_000_000;

    // 10 ms debounce window and 250 ms blink phase at the board clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES   = CLOCK_FREQ_HZ / 100;
    localparam int DEFAULT_BLINK_HALF_PERIOD = CLOCK_FREQ_HZ / 4;

    localparam int DEFAULT_NUM_CHANNELS = 4;

endpackage

// File: rtl/multi_led_toggle_if.sv
// Button/LED bundle between the board pins and multi_led_toggle.
//   button_n   : inverting, asynchronous push buttons (one per channel)
//   blink_mode : per channel, 0 = steady, 1 = blink when enabled
//   led        : registered LED drive
//   pressed    : registered one-cycle pulse per accepted press
// master drives buttons/modes, slave (the toggle block) drives led/pressed.
interface multi_led_toggle_if
    import led_toggle_pkg::*;
#(
    parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS
);

    logic [NUM_CHANNELS-1:0] button_n;
    logic [NUM_CHANNELS-1:0] blink_mode;
    logic [NUM_CHANNELS-1:0] led;
    logic [NUM_CHANNELS-1:0] pressed;

    modport master (
        output button_n,
        output blink_mode,
        input  led,
        input  pressed
    );

    modport slave (
        input  button_n,
        input  blink_mode,
        output led,
        output pressed
    );

endinterface

// File: rtl/multi_led_toggle_button_debouncer.sv
// Single-channel button conditioner: 2-FF synchroniser, counter-based
// debouncer and falling-edge press detector.
//   clock    : system clock
//   reset    : synchronous active-high reset
//   button_n : raw inverting push button
//   pressed  : high for the one cycle in which the debounced level has just
//              fallen (decoded from registers, so glitch-free); the top
//              registers it and toggles its enable on the same edge.
module button_debouncer
    import led_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic pressed
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable_n;
    logic             stable_n_q;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            stable_n   <= 1'b1;
            stable_n_q <= 1'b1;
            count      <= '0;
        end else begin
            sync1      <= button_n;
            sync2      <= sync1;
            stable_n_q <= stable_n;
            // Any return to the accepted level restarts the window.
            if (sync2 == stable_n) begin
                count <= '0;
            end else if (count < CNT_LAST) begin
                count <= count + CNT_W'(1);
            end else begin
                stable_n <= sync2;
                count    <= '0;
            end
        end
    end

    assign pressed = stable_n_q & ~stable_n;

endmodule

// File: rtl/multi_led_toggle.sv
// Multi-channel push-button LED toggle.
// Each channel debounces its button; every accepted press toggles that
// channel's enable. Enabled channels are steady or blink from one shared
// free-running timebase depending on blink_mode.
//   clock : system clock
//   reset : synchronous active-high reset
//   bus   : button_n / blink_mode in, led / pressed out (slave side)
module multi_led_toggle
    import led_toggle_pkg::*;
#(
    parameter int NUM_CHANNELS      = DEFAULT_NUM_CHANNELS,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_HALF_PERIOD = DEFAULT_BLINK_HALF_PERIOD
) (
    input  logic                     clock,
    input  logic                     reset,
    multi_led_toggle_if.slave        bus
);

    localparam int               BLINK_W    = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

    logic [NUM_CHANNELS-1:0] press_now;
    logic [NUM_CHANNELS-1:0] enable;
    logic [BLINK_W-1:0]      blink_count;
    logic                    blink_phase;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock    (clock),
            .reset    (reset),
            .button_n (bus.button_n[i]),
            .pressed  (press_now[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_count <= '0;
            blink_phase <= 1'b1;
            enable      <= '0;
            bus.pressed <= '0;
            bus.led     <= '0;
        end else begin
            // Timebase never restarts on enable/mode changes so all blinking
            // channels stay in phase with each other.
            if (blink_count == BLINK_LAST) begin
                blink_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_count <= blink_count + BLINK_W'(1);
            end
            enable      <= enable ^ press_now;
            bus.pressed <= press_now;
            bus.led     <= enable & (~bus.blink_mode | {NUM_CHANNELS{blink_phase}});
        end
    end

endmodule
